// File: rtl/branch_recovery_unit.sv
// branch_recovery_unit: registers resolved branches, issues predictor updates, squash and fetch redirect.
module branch_recovery_unit #(
  parameter int ADDR_WIDTH    = 32,
  parameter int ROB_IDX_WIDTH = 5,
  parameter int DRAIN_CYCLES  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     br_valid,
  input  logic [ROB_IDX_WIDTH-1:0] br_rob_idx,
  input  logic [ADDR_WIDTH-1:0]    br_pc,
  input  logic                     br_taken,
  input  logic [ADDR_WIDTH-1:0]    br_target,
  input  logic                     br_mispredict,
  input  logic [ROB_IDX_WIDTH-1:0] rob_head,
  input  logic                     ext_flush,
  output logic                     flush_valid,
  output logic [ROB_IDX_WIDTH-1:0] flush_rob_idx,
  output logic                     redirect_valid,
  output logic [ADDR_WIDTH-1:0]    redirect_pc,
  input  logic                     redirect_ready,
  output logic                     fetch_stall,
  output logic                     upd_valid,
  output logic [ADDR_WIDTH-1:0]    upd_pc,
  output logic                     upd_taken,
  output logic [ADDR_WIDTH-1:0]    upd_target
);
  typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;
  localparam int CW = DRAIN_CYCLES > 0 ? $clog2(DRAIN_CYCLES + 1) : 1;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [ROB_IDX_WIDTH-1:0] pend_idx, pend_d, fidx_d, age_br, age_pend;
  logic [ADDR_WIDTH-1:0] rpc_d, upc_d, utgt_d;
  logic rv_d, accept, mis;
  // Ages are distances from the ROB head, so they stay ordered across index wrap.
  assign age_br   = br_rob_idx - rob_head;
  assign age_pend = pend_idx - rob_head;
  assign accept   = br_valid && !ext_flush && (state == IDLE || age_br < age_pend);
  assign mis      = accept && br_mispredict;
  assign fidx_d   = mis ? br_rob_idx : '0;
  assign upc_d    = accept ? br_pc : '0;
  assign utgt_d   = accept ? br_target : '0;
  assign fetch_stall = state != IDLE;
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pend_d  = pend_idx;
    rv_d    = redirect_valid;
    rpc_d   = redirect_pc;
    if (ext_flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      pend_d  = '0;
      rv_d    = 1'b0;
      rpc_d   = '0;
    end else if (mis) begin
      state_d = REDIRECT;
      pend_d  = br_rob_idx;
      rv_d    = 1'b1;
      rpc_d   = br_target;
    end else if (state == REDIRECT && redirect_ready) begin
      state_d = DRAIN_CYCLES == 0 ? IDLE : DRAIN;
      cnt_d   = CW'(DRAIN_CYCLES);
      rv_d    = 1'b0;
      rpc_d   = '0;
    end else if (state == DRAIN) begin
      cnt_d   = cnt - 1'b1;
      state_d = cnt == CW'(1) ? IDLE : DRAIN;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      pend_idx       <= '0;
      flush_valid    <= 1'b0;
      flush_rob_idx  <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      upd_valid      <= 1'b0;
      upd_pc         <= '0;
      upd_taken      <= 1'b0;
      upd_target     <= '0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      pend_idx       <= pend_d;
      flush_valid    <= mis;
      flush_rob_idx  <= fidx_d;
      redirect_valid <= rv_d;
      redirect_pc    <= rpc_d;
      upd_valid      <= accept;
      upd_pc         <= upc_d;
      upd_taken      <= accept && br_taken;
      upd_target     <= utgt_d;
    end
  end
endmodule

// File: tb/tb_branch_recovery_unit.sv
// tb_branch_recovery_unit: directed vectors with hand-computed expectations for branch_recovery_unit.
module tb_branch_recovery_unit;
  logic clk = 1'b0, rst_n, br_valid, br_taken, br_mispredict, ext_flush, redirect_ready;
  logic [4:0] br_rob_idx, rob_head, flush_rob_idx;
  logic [31:0] br_pc, br_target, redirect_pc, upd_pc, upd_target;
  logic flush_valid, redirect_valid, fetch_stall, upd_valid, upd_taken;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  branch_recovery_unit dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_rob_idx(br_rob_idx), .br_pc(br_pc),
    .br_taken(br_taken), .br_target(br_target), .br_mispredict(br_mispredict), .rob_head(rob_head),
    .ext_flush(ext_flush), .flush_valid(flush_valid), .flush_rob_idx(flush_rob_idx),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
    .fetch_stall(fetch_stall), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic br(input logic [4:0] idx, input logic [31:0] pc, input logic tk,
                    input logic [31:0] tgt, input logic mp);
    br_valid = 1'b1; br_rob_idx = idx; br_pc = pc; br_taken = tk; br_target = tgt; br_mispredict = mp;
  endtask
  task automatic no_br();
    br_valid = 1'b0; br_mispredict = 1'b0;
  endtask
  task automatic outs(input string tag, input logic fv, input logic rv, input logic st, input logic uv);
    check({tag, ".flush_valid"}, flush_valid, fv);
    check({tag, ".redirect_valid"}, redirect_valid, rv);
    check({tag, ".fetch_stall"}, fetch_stall, st);
    check({tag, ".upd_valid"}, upd_valid, uv);
  endtask
  initial begin
    rst_n = 1'b0; ext_flush = 1'b0; redirect_ready = 1'b0; rob_head = '0;
    br(5'd4, 32'h80, 1'b1, 32'h90, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      outs("reset", 0, 0, 0, 0);
      check("reset.upd_pc", upd_pc, 0);
    end
    rst_n = 1'b1; no_br();
    tick();
    outs("post_reset", 0, 0, 0, 0);
    br(5'd2, 32'h100, 1'b1, 32'h140, 1'b0);
    tick();
    outs("correct", 0, 0, 0, 1);
    check("correct.upd_pc", upd_pc, 32'h100);
    check("correct.upd_taken", upd_taken, 1);
    check("correct.upd_target", upd_target, 32'h140);
    no_br();
    tick();
    check("correct.upd_pulse", upd_valid, 0);
    rob_head = 5'd3;
    br(5'd7, 32'h1f0, 1'b1, 32'h200, 1'b1);
    tick();
    outs("mp", 1, 1, 1, 1);
    check("mp.flush_idx", flush_rob_idx, 7);
    check("mp.redirect_pc", redirect_pc, 32'h200);
    no_br();
    for (int i = 0; i < 3; i++) begin
      tick();
      outs("mp_hold", 0, 1, 1, 0);
      check("mp_hold.redirect_pc", redirect_pc, 32'h200);
    end
    redirect_ready = 1'b1;
    tick();
    outs("mp_accept", 0, 0, 1, 0);
    redirect_ready = 1'b0;
    tick();
    check("mp_drain1.stall", fetch_stall, 1);
    tick();
    check("mp_drain_done.stall", fetch_stall, 0);
    br(5'd9, 32'h260, 1'b0, 32'h280, 1'b1);
    tick();
    check("sup_first.flush_idx", flush_rob_idx, 9);
    br(5'd5, 32'h2f0, 1'b1, 32'h300, 1'b1);
    tick();
    outs("sup", 1, 1, 1, 1);
    check("sup.flush_idx", flush_rob_idx, 5);
    check("sup.redirect_pc", redirect_pc, 32'h300);
    br(5'd8, 32'h350, 1'b1, 32'h360, 1'b1);
    tick();
    outs("younger", 0, 1, 1, 0);
    check("younger.redirect_pc", redirect_pc, 32'h300);
    no_br(); redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    tick();
    tick();
    check("sup_idle.stall", fetch_stall, 0);
    rob_head = 5'd30;
    br(5'd1, 32'h3f0, 1'b1, 32'h400, 1'b1);
    tick();
    check("wrap_first.flush_idx", flush_rob_idx, 1);
    br(5'd31, 32'h430, 1'b1, 32'h440, 1'b1);
    tick();
    outs("wrap", 1, 1, 1, 1);
    check("wrap.flush_idx", flush_rob_idx, 31);
    check("wrap.redirect_pc", redirect_pc, 32'h440);
    br(5'd30, 32'h470, 1'b1, 32'h480, 1'b1); redirect_ready = 1'b1;
    tick();
    outs("sup_ready", 1, 1, 1, 1);
    check("sup_ready.flush_idx", flush_rob_idx, 30);
    check("sup_ready.redirect_pc", redirect_pc, 32'h480);
    no_br();
    tick();
    outs("to_drain", 0, 0, 1, 0);
    redirect_ready = 1'b0; rob_head = 5'd29; ext_flush = 1'b1;
    br(5'd29, 32'h4f0, 1'b1, 32'h500, 1'b1);
    tick();
    outs("ext", 0, 0, 0, 0);
    check("ext.flush_idx", flush_rob_idx, 0);
    check("ext.redirect_pc", redirect_pc, 0);
    check("ext.upd_pc", upd_pc, 0);
    ext_flush = 1'b0; no_br();
    tick();
    outs("ext_after", 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
